// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 4:1 shared output lane.
// Ports: clk, rst_n, req[3:0], in0..in3 -> gnt, sel, out, out_vld, busy.
module mux4_rr_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] out,
  output logic          out_vld,
  output logic          busy
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    sel_d;
  logic [3:0]    gnt_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [1:0] win;
  logic       own;
  logic       others;
  logic       at_top;
  logic       take;
  logic       drop;

  // Search base+1, base+2, base+3, base; first set bit wins.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] base
  );
    logic [1:0] idx;
    pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + k[1:0];
      if (r[idx]) pick = idx;
    end
  endfunction

  // In GRANT last_q always equals the owner, so one search serves
  // both the initial grant and every handover.
  assign win    = pick(req, last_q);
  assign own    = |(req & gnt);
  assign others = |(req & ~gnt);
  assign at_top = (hold_q == HOLD_TOP);
  assign take   = others && (!own || at_top);
  assign drop   = !own && !others;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      last_q  <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          last_d  = win;
          hold_d  = '0;
        end
      end
      GRANT: begin
        unique case (1'b1)
          take: begin
            gnt_d  = 4'b0001 << win;
            sel_d  = win;
            last_d = win;
            hold_d = '0;
          end
          drop: begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
          default: begin
            // Saturate so a late competitor rotates at once.
            if (!at_top) hold_d = hold_q + 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out = '0;
    if (|gnt) begin
      unique case (sel)
        2'd0: out = in0;
        2'd1: out = in1;
        2'd2: out = in2;
        2'd3: out = in3;
        default: out = '0;
      endcase
    end
    out_vld = (|gnt) && req[sel];
    busy    = (state_q == GRANT);
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (DW=1, MAX_HOLD=8).
// Observed tuple is {gnt, sel, out, out_vld, busy}.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] d = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       dout;
  logic       out_vld;
  logic       busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(
    .DW(1),
    .MAX_HOLD(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .in0(d[0]),
    .in1(d[1]),
    .in2(d[2]),
    .in3(d[3]),
    .gnt(gnt),
    .sel(sel),
    .out(dout),
    .out_vld(out_vld),
    .busy(busy)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] d;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [8:0] tup(
    input logic [3:0] g,
    input logic [1:0] s,
    input logic       o,
    input logic       v,
    input logic       b
  );
    return {g, s, o, v, b};
  endfunction

  task automatic chk(input string nm, input logic [8:0] exp);
    logic [8:0] act;
    act = {gnt, sel, dout, out_vld, busy};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got gnt=%b sel=%0d out=%b vld=%b busy=%b, want gnt=%b sel=%0d out=%b vld=%b busy=%b",
               nm, act[8:5], act[4:3], act[2], act[1], act[0],
               exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] o;

    tbl[0] = '{4'b0000, 4'b1111, tup(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0)};
    tbl[1] = '{4'b0100, 4'b0100, tup(4'b0100, 2'd2, 1'b1, 1'b1, 1'b1)};
    tbl[2] = '{4'b0100, 4'b0000, tup(4'b0100, 2'd2, 1'b0, 1'b1, 1'b1)};
    tbl[3] = '{4'b0000, 4'b0100, tup(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0)};
    tbl[4] = '{4'b1000, 4'b1000, tup(4'b1000, 2'd3, 1'b1, 1'b1, 1'b1)};
    tbl[5] = '{4'b0000, 4'b0000, tup(4'b0000, 2'd3, 1'b0, 1'b0, 1'b0)};
    tbl[6] = '{4'b1010, 4'b0010, tup(4'b0010, 2'd1, 1'b1, 1'b1, 1'b1)};
    tbl[7] = '{4'b0011, 4'b0001, tup(4'b0010, 2'd1, 1'b0, 1'b1, 1'b1)};
    tbl[8] = '{4'b0001, 4'b0001, tup(4'b0001, 2'd0, 1'b1, 1'b1, 1'b1)};
    tbl[9] = '{4'b0000, 4'b0001, tup(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0)};

    #3;
    chk("reset", tup(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    #9 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      d   = tbl[i].d;
      step();
      chk($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Owner drop is visible on out_vld before the next edge.
    req = 4'b0100;
    d   = 4'b0100;
    step();
    chk("drop_pre", tup(4'b0100, 2'd2, 1'b1, 1'b1, 1'b1));
    req = 4'b0000;
    #1;
    chk("drop_comb", tup(4'b0100, 2'd2, 1'b1, 1'b0, 1'b1));
    step();
    chk("drop_idle", tup(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset between edges while lane 1 owns.
    req = 4'b0010;
    d   = 4'b0000;
    step();
    chk("ar_own", tup(4'b0010, 2'd1, 1'b0, 1'b1, 1'b1));
    #3 rst_n = 1'b0;
    #1;
    chk("ar_clear", tup(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    req = 4'b0110;
    #2 rst_n = 1'b1;
    step();
    chk("ar_first", tup(4'b0010, 2'd1, 1'b0, 1'b1, 1'b1));

    // Full contention after a fresh reset: 8 cycles per owner, no gaps.
    #3 rst_n = 1'b0;
    req = 4'b1111;
    d   = 4'b0000;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      o = 2'((c / 8) % 4);
      chk($sformatf("rot%0d", c),
          tup(4'b0001 << o, o, 1'b0, 1'b1, 1'b1));
    end

    req = 4'b0000;
    step();
    chk("rot_idle", tup(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));

    // Sole requester past MAX_HOLD, then a competitor rotates at once.
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("sole%0d", c), tup(4'b1000, 2'd3, 1'b0, 1'b1, 1'b1));
    end
    req = 4'b1001;
    step();
    chk("sole_rot", tup(4'b0001, 2'd0, 1'b0, 1'b1, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
